// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU datapath.
//   ALU_ADD..ALU_SRL : ALUCon operation encodings
//   MEMREAD/MEMWRITE : bit positions inside MEM_Con
//   MEMTOREG/REGWRE  : bit positions inside WB_Con
//   DW_DEF/RW_DEF    : default datapath and register-index widths
package cpu_pkg;

   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam int MEMREAD  = 1;
   localparam int MEMWRITE = 0;
   localparam int MEMTOREG = 1;
   localparam int REGWRE   = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
//   a, b    in  DW  operands
//   alu_con in  3   operation (cpu_pkg ALU_* encodings)
//   result  out DW  operation result
//   zero    out 1   result == 0
module alu
   import cpu_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [2:0]    alu_con,
   output logic [DW-1:0] result,
   output logic          zero
);

   logic [4:0] shamt;
   logic       lt;

   assign shamt = b[4:0];
   assign lt    = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      unique case (alu_con)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(DW-1){1'b0}}, lt};
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register.
// Resolves rs/rt forwarding (EX/MEM first, then MEM/WB), runs the ALU,
// picks the destination and registers everything for the memory stage.
//   CLK, RST (async, active-low)
//   Stall / Flush            : hold / bubble the EX/MEM register (Flush wins)
//   MEM_Con, WB_Con, ALUCon, ALUSrcB, RegDst, ID_EX_* : ID/EX register outputs
//   MEM_WB_RegWre/Dst/Data   : write-back stage forwarding source
//   EX_MEM_*                 : registered outputs to the memory stage
module ex_mem_stage
   import cpu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          Stall,
   input  logic          Flush,
   input  logic [1:0]    MEM_Con,
   input  logic [1:0]    WB_Con,
   input  logic [2:0]    ALUCon,
   input  logic          ALUSrcB,
   input  logic          RegDst,
   input  logic [RW-1:0] ID_EX_Reg_RS,
   input  logic [RW-1:0] ID_EX_Reg_RT,
   input  logic [RW-1:0] ID_EX_Reg_RD,
   input  logic [DW-1:0] ID_EX_Reg_immediate,
   input  logic [DW-1:0] ID_EX_DataBusA,
   input  logic [DW-1:0] ID_EX_DataBusB,
   input  logic          MEM_WB_RegWre,
   input  logic [RW-1:0] MEM_WB_Dst,
   input  logic [DW-1:0] MEM_WB_Data,
   output logic [1:0]    EX_MEM_MEM_Con,
   output logic [1:0]    EX_MEM_WB_Con,
   output logic [DW-1:0] EX_MEM_ALUResult,
   output logic [DW-1:0] EX_MEM_StoreData,
   output logic [RW-1:0] EX_MEM_Dst,
   output logic          EX_MEM_Zero
);

   logic          ex_fwd_ok;
   logic          wb_fwd_ok;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] rt_data;
   logic [DW-1:0] opnd_b;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic [RW-1:0] dst;

   // A load in EX/MEM has no data yet; its consumer is stalled by the
   // hazard unit and later picks the value up from MEM/WB.
   assign ex_fwd_ok = EX_MEM_WB_Con[REGWRE] && !EX_MEM_WB_Con[MEMTOREG]
                      && (EX_MEM_Dst != '0);
   assign wb_fwd_ok = MEM_WB_RegWre && (MEM_WB_Dst != '0);

   always_comb begin
      opnd_a = ID_EX_DataBusA;
      if (ex_fwd_ok && (EX_MEM_Dst == ID_EX_Reg_RS))
         opnd_a = EX_MEM_ALUResult;
      else if (wb_fwd_ok && (MEM_WB_Dst == ID_EX_Reg_RS))
         opnd_a = MEM_WB_Data;
   end

   always_comb begin
      rt_data = ID_EX_DataBusB;
      if (ex_fwd_ok && (EX_MEM_Dst == ID_EX_Reg_RT))
         rt_data = EX_MEM_ALUResult;
      else if (wb_fwd_ok && (MEM_WB_Dst == ID_EX_Reg_RT))
         rt_data = MEM_WB_Data;
   end

   assign opnd_b = ALUSrcB ? ID_EX_Reg_immediate : rt_data;
   assign dst    = RegDst ? ID_EX_Reg_RD : ID_EX_Reg_RT;

   alu #(.DW(DW)) u_alu (
      .a       (opnd_a),
      .b       (opnd_b),
      .alu_con (ALUCon),
      .result  (alu_result),
      .zero    (alu_zero)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         EX_MEM_MEM_Con   <= '0;
         EX_MEM_WB_Con    <= '0;
         EX_MEM_ALUResult <= '0;
         EX_MEM_StoreData <= '0;
         EX_MEM_Dst       <= '0;
         EX_MEM_Zero      <= 1'b0;
      end else if (Flush) begin
         EX_MEM_MEM_Con   <= '0;
         EX_MEM_WB_Con    <= '0;
         EX_MEM_ALUResult <= '0;
         EX_MEM_StoreData <= '0;
         EX_MEM_Dst       <= '0;
         EX_MEM_Zero      <= 1'b0;
      end else if (!Stall) begin
         EX_MEM_MEM_Con   <= MEM_Con;
         EX_MEM_WB_Con    <= WB_Con;
         EX_MEM_ALUResult <= alu_result;
         EX_MEM_StoreData <= rt_data;
         EX_MEM_Dst       <= dst;
         EX_MEM_Zero      <= alu_zero;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, ALU ops, forwarding priority,
// load/r0 forwarding guards, stall and flush.
module tb_ex_mem_stage;

   logic        CLK;
   logic        RST;
   logic        Stall;
   logic        Flush;
   logic [1:0]  MEM_Con;
   logic [1:0]  WB_Con;
   logic [2:0]  ALUCon;
   logic        ALUSrcB;
   logic        RegDst;
   logic [4:0]  ID_EX_Reg_RS;
   logic [4:0]  ID_EX_Reg_RT;
   logic [4:0]  ID_EX_Reg_RD;
   logic [31:0] ID_EX_Reg_immediate;
   logic [31:0] ID_EX_DataBusA;
   logic [31:0] ID_EX_DataBusB;
   logic        MEM_WB_RegWre;
   logic [4:0]  MEM_WB_Dst;
   logic [31:0] MEM_WB_Data;
   logic [1:0]  EX_MEM_MEM_Con;
   logic [1:0]  EX_MEM_WB_Con;
   logic [31:0] EX_MEM_ALUResult;
   logic [31:0] EX_MEM_StoreData;
   logic [4:0]  EX_MEM_Dst;
   logic        EX_MEM_Zero;

   int passed = 0;
   int total  = 0;

   ex_mem_stage dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .Stall               (Stall),
      .Flush               (Flush),
      .MEM_Con             (MEM_Con),
      .WB_Con              (WB_Con),
      .ALUCon              (ALUCon),
      .ALUSrcB             (ALUSrcB),
      .RegDst              (RegDst),
      .ID_EX_Reg_RS        (ID_EX_Reg_RS),
      .ID_EX_Reg_RT        (ID_EX_Reg_RT),
      .ID_EX_Reg_RD        (ID_EX_Reg_RD),
      .ID_EX_Reg_immediate (ID_EX_Reg_immediate),
      .ID_EX_DataBusA      (ID_EX_DataBusA),
      .ID_EX_DataBusB      (ID_EX_DataBusB),
      .MEM_WB_RegWre       (MEM_WB_RegWre),
      .MEM_WB_Dst          (MEM_WB_Dst),
      .MEM_WB_Data         (MEM_WB_Data),
      .EX_MEM_MEM_Con      (EX_MEM_MEM_Con),
      .EX_MEM_WB_Con       (EX_MEM_WB_Con),
      .EX_MEM_ALUResult    (EX_MEM_ALUResult),
      .EX_MEM_StoreData    (EX_MEM_StoreData),
      .EX_MEM_Dst          (EX_MEM_Dst),
      .EX_MEM_Zero         (EX_MEM_Zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] alu, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic regdst, input logic srcb,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [1:0] mem,
                           input logic [1:0] wb);
      ALUCon              = alu;
      ID_EX_Reg_RS        = rs;
      ID_EX_Reg_RT        = rt;
      ID_EX_Reg_RD        = rd;
      RegDst              = regdst;
      ALUSrcB             = srcb;
      ID_EX_DataBusA      = a;
      ID_EX_DataBusB      = b;
      ID_EX_Reg_immediate = imm;
      MEM_Con             = mem;
      WB_Con              = wb;
   endtask

   task automatic drive_wb(input logic wre, input logic [4:0] d, input logic [31:0] data);
      MEM_WB_RegWre = wre;
      MEM_WB_Dst    = d;
      MEM_WB_Data   = data;
   endtask

   task automatic test_reset();
      RST = 1'b0; Stall = 1'b0; Flush = 1'b0;
      drive_op(3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 2'b01, 2'b01);
      drive_wb(1'b0, 5'd0, 32'h0);
      #2;
      total++;
      if ({EX_MEM_MEM_Con, EX_MEM_WB_Con, EX_MEM_ALUResult, EX_MEM_StoreData,
           EX_MEM_Dst, EX_MEM_Zero} !== 74'd0)
         $display("FAIL reset_initial: outputs=%h expected all zero",
                  {EX_MEM_MEM_Con, EX_MEM_WB_Con, EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_Dst, EX_MEM_Zero});
      else passed++;
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd0 || EX_MEM_Dst !== 5'd0 || EX_MEM_WB_Con !== 2'b00)
         $display("FAIL reset_held: result=%h dst=%0d wb=%b expected 0/0/00",
                  EX_MEM_ALUResult, EX_MEM_Dst, EX_MEM_WB_Con);
      else passed++;
      RST = 1'b1;
   endtask

   task automatic test_no_hazard();
      drive_op(3'b001, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'd5, 32'd3, 32'd0, 2'b00, 2'b01);
      drive_wb(1'b0, 5'd0, 32'h0);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd2 || EX_MEM_Dst !== 5'd7 || EX_MEM_Zero !== 1'b0
          || EX_MEM_WB_Con !== 2'b01 || EX_MEM_StoreData !== 32'd3 || EX_MEM_MEM_Con !== 2'b00)
         $display("FAIL no_hazard_sub: result=%h dst=%0d zero=%b wb=%b sd=%h mem=%b expected 2/7/0/01/3/00",
                  EX_MEM_ALUResult, EX_MEM_Dst, EX_MEM_Zero, EX_MEM_WB_Con, EX_MEM_StoreData, EX_MEM_MEM_Con);
      else passed++;
   endtask

   task automatic test_double_forward();
      // r4 <= 0x10
      drive_op(3'b000, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 32'h10, 32'h0, 32'h0, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h10 || EX_MEM_Dst !== 5'd4)
         $display("FAIL fwd_setup: result=%h dst=%0d expected 10/4", EX_MEM_ALUResult, EX_MEM_Dst);
      else passed++;
      // rs=4 hits both EX/MEM (0x10) and MEM/WB (0x99); EX/MEM must win
      drive_op(3'b000, 5'd4, 5'd2, 5'd5, 1'b1, 1'b1, 32'h55, 32'h0, 32'h1, 2'b00, 2'b01);
      drive_wb(1'b1, 5'd4, 32'h99);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h11)
         $display("FAIL fwd_priority: result=%h expected 00000011", EX_MEM_ALUResult);
      else passed++;
      // rs=4 now only in MEM/WB (0x99); rt=5 from EX/MEM (0x11) into store data
      drive_op(3'b000, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'h55, 32'h66, 32'h1, 2'b01, 2'b00);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h9A || EX_MEM_StoreData !== 32'h11 || EX_MEM_MEM_Con !== 2'b01)
         $display("FAIL fwd_wb_and_rt: result=%h sd=%h mem=%b expected 9a/11/01",
                  EX_MEM_ALUResult, EX_MEM_StoreData, EX_MEM_MEM_Con);
      else passed++;
   endtask

   task automatic test_load_not_forwarded();
      drive_wb(1'b0, 5'd0, 32'h0);
      // load into r4 (dest via rt)
      drive_op(3'b000, 5'd1, 5'd4, 5'd9, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 2'b10, 2'b11);
      tick();
      total++;
      if (EX_MEM_WB_Con !== 2'b11 || EX_MEM_MEM_Con !== 2'b10 || EX_MEM_Dst !== 5'd4)
         $display("FAIL load_setup: wb=%b mem=%b dst=%0d expected 11/10/4",
                  EX_MEM_WB_Con, EX_MEM_MEM_Con, EX_MEM_Dst);
      else passed++;
      drive_op(3'b000, 5'd4, 5'd4, 5'd6, 1'b1, 1'b1, 32'h77, 32'h88, 32'h0, 2'b00, 2'b01);
      drive_wb(1'b1, 5'd4, 32'h20);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h20 || EX_MEM_StoreData !== 32'h20)
         $display("FAIL load_not_fwd: result=%h sd=%h expected 20/20", EX_MEM_ALUResult, EX_MEM_StoreData);
      else passed++;
   endtask

   task automatic test_r0_guard();
      drive_wb(1'b0, 5'd0, 32'h0);
      drive_op(3'b000, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 32'hFF, 32'h0, 32'h0, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_Dst !== 5'd0 || EX_MEM_ALUResult !== 32'hFF || EX_MEM_WB_Con !== 2'b01)
         $display("FAIL r0_capture: dst=%0d result=%h wb=%b expected 0/ff/01",
                  EX_MEM_Dst, EX_MEM_ALUResult, EX_MEM_WB_Con);
      else passed++;
      drive_op(3'b000, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01);
      drive_wb(1'b1, 5'd0, 32'hAB);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h0 || EX_MEM_Zero !== 1'b1 || EX_MEM_StoreData !== 32'h0)
         $display("FAIL r0_guard: result=%h zero=%b sd=%h expected 0/1/0",
                  EX_MEM_ALUResult, EX_MEM_Zero, EX_MEM_StoreData);
      else passed++;
   endtask

   task automatic test_stall_flush();
      drive_wb(1'b0, 5'd0, 32'h0);
      drive_op(3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1234, 32'h0, 32'h0, 2'b01, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h1234 || EX_MEM_Dst !== 5'd3)
         $display("FAIL stall_setup: result=%h dst=%0d expected 1234/3", EX_MEM_ALUResult, EX_MEM_Dst);
      else passed++;
      Stall = 1'b1;
      drive_op(3'b011, 5'd8, 5'd9, 5'd9, 1'b1, 1'b0, 32'h9999, 32'h1, 32'h0, 2'b10, 2'b10);
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (EX_MEM_ALUResult !== 32'h1234 || EX_MEM_Dst !== 5'd3 || EX_MEM_MEM_Con !== 2'b01
             || EX_MEM_WB_Con !== 2'b01 || EX_MEM_Zero !== 1'b0)
            $display("FAIL stall_hold_%0d: result=%h dst=%0d mem=%b wb=%b zero=%b expected 1234/3/01/01/0",
                     i, EX_MEM_ALUResult, EX_MEM_Dst, EX_MEM_MEM_Con, EX_MEM_WB_Con, EX_MEM_Zero);
         else passed++;
      end
      Flush = 1'b1;
      tick();
      total++;
      if (EX_MEM_MEM_Con !== 2'b00 || EX_MEM_WB_Con !== 2'b00 || EX_MEM_Dst !== 5'd0
          || EX_MEM_ALUResult !== 32'd0 || EX_MEM_StoreData !== 32'd0)
         $display("FAIL flush_over_stall: mem=%b wb=%b dst=%0d result=%h sd=%h expected all 0",
                  EX_MEM_MEM_Con, EX_MEM_WB_Con, EX_MEM_Dst, EX_MEM_ALUResult, EX_MEM_StoreData);
      else passed++;
      Stall = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic test_alu_ops();
      drive_wb(1'b0, 5'd0, 32'h0);
      drive_op(3'b101, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd1 || EX_MEM_Zero !== 1'b0)
         $display("FAIL slt_signed: result=%h zero=%b expected 1/0", EX_MEM_ALUResult, EX_MEM_Zero);
      else passed++;
      drive_op(3'b111, 5'd1, 5'd3, 5'd3, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'd31, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd1)
         $display("FAIL srl_31: result=%h expected 1", EX_MEM_ALUResult);
      else passed++;
      drive_op(3'b110, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 32'h0000_0003, 32'h0, 32'h24, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'h30)
         $display("FAIL sll_shamt_low5: result=%h expected 30", EX_MEM_ALUResult);
      else passed++;
      drive_op(3'b100, 5'd1, 5'd6, 5'd6, 1'b1, 1'b0, 32'hF0F0_00FF, 32'h0FF0_00F0, 32'h0, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'hFF00_000F)
         $display("FAIL xor: result=%h expected ff00000f", EX_MEM_ALUResult);
      else passed++;
      drive_op(3'b001, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, 32'h1, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'hFFFF_FFFF || EX_MEM_Zero !== 1'b0)
         $display("FAIL sub_wrap: result=%h zero=%b expected ffffffff/0", EX_MEM_ALUResult, EX_MEM_Zero);
      else passed++;
   endtask

   task automatic test_reset_midrun();
      #3;
      RST = 1'b0;
      #1;
      total++;
      if ({EX_MEM_MEM_Con, EX_MEM_WB_Con, EX_MEM_ALUResult, EX_MEM_StoreData,
           EX_MEM_Dst, EX_MEM_Zero} !== 74'd0)
         $display("FAIL reset_async: result=%h dst=%0d wb=%b expected all zero",
                  EX_MEM_ALUResult, EX_MEM_Dst, EX_MEM_WB_Con);
      else passed++;
      drive_op(3'b001, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'd5, 32'd3, 32'd0, 2'b00, 2'b01);
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd0 || EX_MEM_Dst !== 5'd0)
         $display("FAIL reset_hold_edge: result=%h dst=%0d expected 0/0", EX_MEM_ALUResult, EX_MEM_Dst);
      else passed++;
      #2;
      RST = 1'b1;
      tick();
      total++;
      if (EX_MEM_ALUResult !== 32'd2 || EX_MEM_Dst !== 5'd7 || EX_MEM_WB_Con !== 2'b01)
         $display("FAIL reset_first_capture: result=%h dst=%0d wb=%b expected 2/7/01",
                  EX_MEM_ALUResult, EX_MEM_Dst, EX_MEM_WB_Con);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_no_hazard();
      test_double_forward();
      test_load_not_forwarded();
      test_r0_guard();
      test_stall_flush();
      test_alu_ops();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
